// File: rtl/fetch_pkg.sv
// Shared fetch definitions: FSM state encoding and the instruction word width
// common to the fetch unit and the instruction register.
package fetch_pkg;

  localparam int unsigned FETCH_INSTR_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_LOAD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_counter.sv
// Program counter register: sync reset to RESET_PC, jump load, and modulo-2^PC_W increment.
module fetch_pc_counter #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_load,
  input  logic [PC_W-1:0] i_load_val,
  input  logic            i_inc,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc <= PC_W'(RESET_PC);
    end else if (i_load) begin
      r_pc <= i_load_val;
    end else if (i_inc) begin
      r_pc <= r_pc + PC_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: reads one word at PC from program memory and loads it into the IR.
// Optional build macro IFU_FETCH_COUNT_EN adds a 16-bit count of completed fetches.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W           = 8,
  parameter int unsigned INSTR_W        = FETCH_INSTR_W,
  parameter int unsigned RESET_PC       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_fetch_req,
  input  logic               i_halt,
  input  logic               i_jump_en,
  input  logic [PC_W-1:0]    i_jump_addr,
  output logic               o_mem_rd,
  output logic [PC_W-1:0]    o_mem_addr,
  input  logic               i_mem_valid,
  input  logic [INSTR_W-1:0] i_mem_data,
  output logic               o_ir_load,
  output logic [INSTR_W-1:0] o_ir_value,
  output logic               o_fetch_done,
  output logic               o_fetch_err,
  output logic               o_busy,
`ifdef IFU_FETCH_COUNT_EN
  output logic [15:0]        o_fetch_count,
`endif
  output logic [PC_W-1:0]    o_pc
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  fetch_state_t        r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_mem_rd;
  logic [PC_W-1:0]     r_mem_addr;
  logic                r_ir_load;
  logic [INSTR_W-1:0]  r_ir_value;
  logic                r_fetch_done;
  logic                r_fetch_err;
  logic                r_busy;
  logic [PC_W-1:0]     w_pc;
  logic                w_pc_load;
  logic                w_pc_inc;

  // Jumps are only legal in IDLE; PC advances on leaving LOAD.
  assign w_pc_load = (r_state == S_IDLE) && i_jump_en;
  assign w_pc_inc  = (r_state == S_LOAD);

  fetch_pc_counter #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_pc_load),
    .i_load_val (i_jump_addr),
    .i_inc      (w_pc_inc),
    .o_pc       (w_pc)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_addr   <= '0;
      r_ir_load    <= 1'b0;
      r_ir_value   <= '0;
      r_fetch_done <= 1'b0;
      r_fetch_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_mem_rd     <= 1'b0;
      r_ir_load    <= 1'b0;
      r_fetch_done <= 1'b0;
      r_fetch_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_fetch_req && !i_halt) begin
            r_state    <= S_REQ;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= i_jump_en ? i_jump_addr : w_pc;
            r_busy     <= 1'b1;
          end
        end
        S_REQ: begin
          r_state <= S_WAIT;
          r_cnt   <= '0;
        end
        S_WAIT: begin
          if (i_mem_valid) begin
            r_state      <= S_LOAD;
            r_ir_value   <= i_mem_data;
            r_ir_load    <= 1'b1;
            r_fetch_done <= 1'b1;
          end else if (r_cnt == CNT_LAST) begin
            r_state     <= S_IDLE;
            r_fetch_err <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_LOAD: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFU_FETCH_COUNT_EN
  logic [15:0] r_fetch_count;

  // Counts completed loads only; wraps naturally at 16 bits.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fetch_count <= '0;
    end else if (r_state == S_LOAD) begin
      r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  assign o_fetch_count = r_fetch_count;
`endif

  assign o_mem_rd     = r_mem_rd;
  assign o_mem_addr   = r_mem_addr;
  assign o_ir_load    = r_ir_load;
  assign o_ir_value   = r_ir_value;
  assign o_fetch_done = r_fetch_done;
  assign o_fetch_err  = r_fetch_err;
  assign o_busy       = r_busy;
  assign o_pc         = w_pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit against a transaction-level PC/IR model.
// Build with IFU_FETCH_COUNT_EN defined to also exercise the fetch counter.
module tb_instruction_fetch_unit;

  localparam int TIMEOUT = 15;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic        halt;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic        mem_valid;
  logic [15:0] mem_data;
  logic        ir_load;
  logic [15:0] ir_value;
  logic        fetch_done;
  logic        fetch_err;
  logic        busy;
  logic [7:0]  pc;
`ifdef IFU_FETCH_COUNT_EN
  logic [15:0] fetch_count;
`endif

  int checks;
  int failures;

  // Reference model state
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  int          m_cnt;

  instruction_fetch_unit dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_fetch_req  (fetch_req),
    .i_halt       (halt),
    .i_jump_en    (jump_en),
    .i_jump_addr  (jump_addr),
    .o_mem_rd     (mem_rd),
    .o_mem_addr   (mem_addr),
    .i_mem_valid  (mem_valid),
    .i_mem_data   (mem_data),
    .o_ir_load    (ir_load),
    .o_ir_value   (ir_value),
    .o_fetch_done (fetch_done),
    .o_fetch_err  (fetch_err),
    .o_busy       (busy),
`ifdef IFU_FETCH_COUNT_EN
    .o_fetch_count(fetch_count),
`endif
    .o_pc         (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one fetch; lat = WAIT cycles without mem_valid before it is asserted
  // (lat >= TIMEOUT means never). Returns what was observed.
  task automatic run_fetch(input bit jmp, input logic [7:0] ja, input int lat,
                           input logic [15:0] data, input bit halt_mid,
                           output logic rd, output logic [7:0] addr,
                           output logic ld, output logic [15:0] val,
                           output logic done, output logic err,
                           output logic [7:0] pc_a, output logic busy_a);
    jump_en   = jmp;
    jump_addr = ja;
    fetch_req = 1'b1;
    tick;
    jump_en   = 1'b0;
    fetch_req = 1'b0;
    halt      = halt_mid;
    rd   = mem_rd;
    addr = mem_addr;
    tick;
    for (int i = 0; i < lat && i < TIMEOUT; i++) tick;
    if (lat < TIMEOUT) begin
      mem_valid = 1'b1;
      mem_data  = data;
      tick;
      mem_valid = 1'b0;
      mem_data  = 16'($urandom);
      ld = ir_load; val = ir_value; done = fetch_done; err = fetch_err;
      tick;
    end else begin
      ld = ir_load; val = ir_value; done = fetch_done; err = fetch_err;
    end
    pc_a   = pc;
    busy_a = busy;
    halt   = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    m_pc = 8'h00; m_ir = 16'h0000; m_cnt = 0;
    checks++;
    if ({mem_rd, ir_load, fetch_done, fetch_err, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=00000", {mem_rd, ir_load, fetch_done, fetch_err, busy});
    end
    checks++;
    if (pc !== 8'h00 || ir_value !== 16'h0000) begin
      failures++;
      $display("FAIL reset_pc_ir got pc=%h ir=%h exp pc=00 ir=0000", pc, ir_value);
    end
  endtask

  task automatic test_basic_fetch;
    logic rd, ld, done, err, b; logic [7:0] a, p; logic [15:0] v;
    run_fetch(1'b0, 8'h00, 0, 16'hFDFD, 1'b0, rd, a, ld, v, done, err, p, b);
    m_ir = 16'hFDFD; m_pc = m_pc + 8'd1; m_cnt++;
    checks++;
    if (rd !== 1'b1 || a !== 8'h00) begin
      failures++;
      $display("FAIL basic_req got rd=%b addr=%h exp rd=1 addr=00", rd, a);
    end
    checks++;
    if (ld !== 1'b1 || done !== 1'b1 || v !== 16'hFDFD) begin
      failures++;
      $display("FAIL basic_load got ld=%b done=%b ir=%h exp 1 1 FDFD", ld, done, v);
    end
    checks++;
    if (p !== 8'h01 || b !== 1'b0 || ir_load !== 1'b0) begin
      failures++;
      $display("FAIL basic_after got pc=%h busy=%b ld=%b exp 01 0 0", p, b, ir_load);
    end
  endtask

  task automatic test_jump_fetch;
    logic rd, ld, done, err, b; logic [7:0] a, p; logic [15:0] v;
    run_fetch(1'b1, 8'h40, 2, 16'hBABA, 1'b0, rd, a, ld, v, done, err, p, b);
    m_ir = 16'hBABA; m_pc = 8'h41; m_cnt++;
    checks++;
    if (a !== 8'h40 || v !== 16'hBABA || p !== 8'h41) begin
      failures++;
      $display("FAIL jump_fetch got addr=%h ir=%h pc=%h exp 40 BABA 41", a, v, p);
    end
  endtask

  task automatic test_pc_wrap;
    logic rd, ld, done, err, b; logic [7:0] a, p; logic [15:0] v;
    jump_en = 1'b1; jump_addr = 8'hFF;
    tick;
    jump_en = 1'b0;
    m_pc = 8'hFF;
    checks++;
    if (pc !== 8'hFF || busy !== 1'b0) begin
      failures++;
      $display("FAIL jump_only got pc=%h busy=%b exp FF 0", pc, busy);
    end
    run_fetch(1'b0, 8'h00, 1, 16'h1234, 1'b0, rd, a, ld, v, done, err, p, b);
    m_ir = 16'h1234; m_pc = m_pc + 8'd1; m_cnt++;
    checks++;
    if (a !== 8'hFF || p !== 8'h00) begin
      failures++;
      $display("FAIL pc_wrap got addr=%h pc=%h exp FF 00", a, p);
    end
  endtask

  task automatic test_timeout;
    logic rd, ld, done, err, b; logic [7:0] a, p; logic [15:0] v;
    run_fetch(1'b0, 8'h00, TIMEOUT, 16'h0000, 1'b0, rd, a, ld, v, done, err, p, b);
    checks++;
    if (err !== 1'b1 || b !== 1'b0 || ld !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err got err=%b busy=%b ld=%b exp 1 0 0", err, b, ld);
    end
    checks++;
    if (p !== m_pc || v !== m_ir) begin
      failures++;
      $display("FAIL timeout_hold got pc=%h ir=%h exp %h %h", p, v, m_pc, m_ir);
    end
    tick;
    checks++;
    if (fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse got err=%b exp 0", fetch_err);
    end
    // mem_valid on the last allowed WAIT cycle still completes the fetch
    run_fetch(1'b0, 8'h00, TIMEOUT - 1, 16'h5A5A, 1'b0, rd, a, ld, v, done, err, p, b);
    m_ir = 16'h5A5A; m_pc = m_pc + 8'd1; m_cnt++;
    checks++;
    if (ld !== 1'b1 || err !== 1'b0 || v !== m_ir || p !== m_pc) begin
      failures++;
      $display("FAIL timeout_edge got ld=%b err=%b ir=%h pc=%h exp 1 0 %h %h", ld, err, v, p, m_ir, m_pc);
    end
  endtask

  task automatic test_halt;
    logic rd, ld, done, err, b; logic [7:0] a, p; logic [15:0] v;
    halt = 1'b1; fetch_req = 1'b1;
    tick;
    checks++;
    if (mem_rd !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL halt_block got rd=%b busy=%b exp 0 0", mem_rd, busy);
    end
    tick;
    fetch_req = 1'b0; halt = 1'b0;
    checks++;
    if (mem_rd !== 1'b0 || pc !== m_pc) begin
      failures++;
      $display("FAIL halt_hold got rd=%b pc=%h exp 0 %h", mem_rd, pc, m_pc);
    end
    // halt raised mid-fetch does not abort it
    run_fetch(1'b0, 8'h00, 3, 16'hC0DE, 1'b1, rd, a, ld, v, done, err, p, b);
    m_ir = 16'hC0DE; m_pc = m_pc + 8'd1; m_cnt++;
    checks++;
    if (ld !== 1'b1 || v !== m_ir || p !== m_pc) begin
      failures++;
      $display("FAIL halt_midfetch got ld=%b ir=%h pc=%h exp 1 %h %h", ld, v, p, m_ir, m_pc);
    end
  endtask

  task automatic test_reset_mid_fetch;
    fetch_req = 1'b1;
    tick;
    fetch_req = 1'b0;
    tick; tick;
    reset = 1'b1; mem_valid = 1'b1; mem_data = 16'hDEAD;
    tick;
    reset = 1'b0; mem_valid = 1'b0;
    m_pc = 8'h00; m_ir = 16'h0000; m_cnt = 0;
    checks++;
    if (busy !== 1'b0 || pc !== 8'h00 || ir_value !== 16'h0000 || ir_load !== 1'b0) begin
      failures++;
      $display("FAIL reset_midfetch got busy=%b pc=%h ir=%h ld=%b exp 0 00 0000 0", busy, pc, ir_value, ir_load);
    end
    tick;
    checks++;
    if (ir_load !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_midfetch_after got ld=%b busy=%b exp 0 0", ir_load, busy);
    end
  endtask

  task automatic test_random;
    logic rd, ld, done, err, b; logic [7:0] a, p, ja; logic [15:0] v, d;
    bit jmp; int lat; logic [7:0] exp_addr;
    for (int n = 0; n < 40; n++) begin
      jmp = ($urandom_range(0, 3) == 0);
      ja  = 8'($urandom);
      d   = 16'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        halt = 1'b1; fetch_req = 1'b1; jump_en = jmp; jump_addr = ja;
        tick;
        halt = 1'b0; fetch_req = 1'b0; jump_en = 1'b0;
        if (jmp) m_pc = ja;
        checks++;
        if (mem_rd !== 1'b0 || busy !== 1'b0 || pc !== m_pc) begin
          failures++;
          $display("FAIL rand_halt[%0d] got rd=%b busy=%b pc=%h exp 0 0 %h", n, mem_rd, busy, pc, m_pc);
        end
      end else begin
        lat = int'($urandom_range(0, 17));
        if (jmp) m_pc = ja;
        exp_addr = m_pc;
        run_fetch(jmp, ja, lat, d, 1'b0, rd, a, ld, v, done, err, p, b);
        if (lat < TIMEOUT) begin
          m_ir = d; m_pc = m_pc + 8'd1; m_cnt++;
        end
        checks++;
        if (rd !== 1'b1 || a !== exp_addr) begin
          failures++;
          $display("FAIL rand_req[%0d] got rd=%b addr=%h exp 1 %h", n, rd, a, exp_addr);
        end
        checks++;
        if (ld !== (lat < TIMEOUT) || done !== (lat < TIMEOUT) || err !== (lat >= TIMEOUT)) begin
          failures++;
          $display("FAIL rand_strobes[%0d] got ld=%b done=%b err=%b lat=%0d", n, ld, done, err, lat);
        end
        checks++;
        if (v !== m_ir || p !== m_pc || b !== 1'b0) begin
          failures++;
          $display("FAIL rand_state[%0d] got ir=%h pc=%h busy=%b exp %h %h 0", n, v, p, b, m_ir, m_pc);
        end
      end
`ifdef IFU_FETCH_COUNT_EN
      checks++;
      if (fetch_count !== 16'(m_cnt)) begin
        failures++;
        $display("FAIL rand_count[%0d] got %0d exp %0d", n, fetch_count, m_cnt);
      end
`endif
    end
  endtask

`ifdef IFU_FETCH_COUNT_EN
  task automatic test_fetch_count;
    logic rd, ld, done, err, b; logic [7:0] a, p; logic [15:0] v;
    reset = 1'b1; tick; reset = 1'b0;
    m_pc = 8'h00; m_ir = 16'h0000; m_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      run_fetch(1'b0, 8'h00, i, 16'(i + 1), 1'b0, rd, a, ld, v, done, err, p, b);
      m_ir = 16'(i + 1); m_pc = m_pc + 8'd1; m_cnt++;
    end
    run_fetch(1'b0, 8'h00, TIMEOUT, 16'h0000, 1'b0, rd, a, ld, v, done, err, p, b);
    tick;
    checks++;
    if (fetch_count !== 16'd3) begin
      failures++;
      $display("FAIL fetch_count got %0d exp 3", fetch_count);
    end
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; fetch_req = 1'b0; halt = 1'b0; jump_en = 1'b0;
    jump_addr = 8'h00; mem_valid = 1'b0; mem_data = 16'h0000;
    m_pc = 8'h00; m_ir = 16'h0000; m_cnt = 0;
    #2;
    test_reset;
    test_basic_fetch;
    test_jump_fetch;
    test_pc_wrap;
    test_timeout;
    test_halt;
    test_reset_mid_fetch;
    test_random;
`ifdef IFU_FETCH_COUNT_EN
    test_fetch_count;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
